framebuffer_stream_responder: RTL and testbench

Memory-side responder for the internal framebuffer's stream/address interface. It accepts one request at a time on the address channel (`avalid`/`aaddr`/`abeats`/`arnw`). A write request (`arnw`=0) consumes the framebuffer's outgoing AXIS stream and turns it into word writes on a simple memory port. A read request (`arnw`=1) issues word reads, buffers the responses in a small FIFO, and streams them back as AXIS into the framebuffer's `s_axis` input. It sits between the framebuffer command handler and the external memory controller.

---
 rtl/framebuffer_stream_responder.sv | 205 ++++++++++++++++++++
 tb/tb_framebuffer_stream_responder.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/framebuffer_stream_responder.sv
// Memory-side responder for the framebuffer stream/address interface.
// Accepts one request at a time. Writes pass the incoming AXIS stream straight
// through to the memory write port; reads issue credit-limited word reads,
// buffer the responses in a small FIFO and stream them out as AXIS.
//
// Ports:
//   aclk, resetn                      clock, async active-low reset
//   s_avalid/s_aready/s_aaddr/s_abeats/s_arnw   request channel
//   s_axis_*                          write-data stream (in)
//   m_axis_*                          read-data stream (out)
//   mem_w*                            memory write port
//   mem_ar*, mem_rvalid/mem_rdata     memory read request / response
//   busy                              not IDLE
//   err_last                          sticky tlast/beat-count disagreement
module framebuffer_stream_responder #(
    parameter int unsigned STREAM_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH    = 32,
    parameter int unsigned FIFO_DEPTH_LG = 2
) (
    input  logic                      aclk,
    input  logic                      resetn,

    input  logic                      s_avalid,
    output logic                      s_aready,
    input  logic [ADDR_WIDTH-1:0]     s_aaddr,
    input  logic [ADDR_WIDTH-1:0]     s_abeats,
    input  logic                      s_arnw,

    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    input  logic                      s_axis_tlast,
    input  logic [STREAM_WIDTH-1:0]   s_axis_tdata,
    input  logic [STREAM_WIDTH/8-1:0] s_axis_tstrb,

    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic                      m_axis_tlast,
    output logic [STREAM_WIDTH-1:0]   m_axis_tdata,

    output logic                      mem_wvalid,
    input  logic                      mem_wready,
    output logic [ADDR_WIDTH-1:0]     mem_waddr,
    output logic [STREAM_WIDTH-1:0]   mem_wdata,
    output logic [STREAM_WIDTH/8-1:0] mem_wstrb,

    output logic                      mem_arvalid,
    input  logic                      mem_arready,
    output logic [ADDR_WIDTH-1:0]     mem_araddr,
    input  logic                      mem_rvalid,
    input  logic [STREAM_WIDTH-1:0]   mem_rdata,

    output logic                      busy,
    output logic                      err_last
);

    localparam int unsigned BYTES    = STREAM_WIDTH / 8;
    localparam int unsigned DEPTH    = 1 << FIFO_DEPTH_LG;
    localparam int unsigned CNT_W    = FIFO_DEPTH_LG + 1;
    localparam int unsigned CREDIT_W = CNT_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0]    addr;
    logic [ADDR_WIDTH-1:0]    req_remaining;   // write beats left, or read requests left
    logic [ADDR_WIDTH-1:0]    pop_remaining;   // read beats still to deliver on m_axis
    logic [CNT_W-1:0]         outstanding;
    logic [CNT_W-1:0]         fifo_count;
    logic [FIFO_DEPTH_LG-1:0] wr_ptr;
    logic [FIFO_DEPTH_LG-1:0] rd_ptr;
    logic [STREAM_WIDTH-1:0]  fifo_mem [DEPTH];

    logic a_hs;
    logic w_hs;
    logic ar_hs;
    logic push;
    logic pop;
    logic credit_ok;

    assign a_hs  = s_avalid && s_aready;
    assign w_hs  = (state == WRITE) && s_axis_tvalid && mem_wready;
    assign ar_hs = mem_arvalid && mem_arready;
    // Responses outside READ belong to an aborted transfer and are dropped.
    assign push  = (state == READ) && mem_rvalid;
    assign pop   = m_axis_tvalid && m_axis_tready;

    // Reads in flight plus buffered words may never exceed the FIFO depth.
    assign credit_ok = (CREDIT_W'(outstanding) + CREDIT_W'(fifo_count)) < CREDIT_W'(DEPTH);

    assign mem_waddr  = addr;
    assign mem_araddr = addr;

    // State register
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and per-state outputs
    always_comb begin
        state_next    = state;
        s_aready      = 1'b0;
        busy          = 1'b1;
        s_axis_tready = 1'b0;
        mem_wvalid    = 1'b0;
        mem_wdata     = '0;
        mem_wstrb     = '0;
        mem_arvalid   = 1'b0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tlast  = 1'b0;
        case (state)
            IDLE: begin
                s_aready = 1'b1;
                busy     = 1'b0;
                if (s_avalid && (s_abeats != '0)) begin
                    state_next = s_arnw ? READ : WRITE;
                end
            end
            WRITE: begin
                mem_wvalid    = s_axis_tvalid;
                s_axis_tready = mem_wready;
                mem_wdata     = s_axis_tdata;
                mem_wstrb     = s_axis_tstrb;
                if (s_axis_tvalid && mem_wready && (req_remaining == ADDR_WIDTH'(1))) begin
                    state_next = IDLE;
                end
            end
            READ: begin
                mem_arvalid   = (req_remaining != '0) && credit_ok;
                m_axis_tvalid = (fifo_count != '0);
                m_axis_tdata  = (fifo_count != '0) ? fifo_mem[rd_ptr] : '0;
                m_axis_tlast  = (pop_remaining == ADDR_WIDTH'(1));
                if ((fifo_count != '0) && m_axis_tready && (pop_remaining == ADDR_WIDTH'(1))) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Address, counters, FIFO pointers and error flag
    always_ff @(posedge aclk or negedge resetn) begin
        if (!resetn) begin
            addr          <= '0;
            req_remaining <= '0;
            pop_remaining <= '0;
            outstanding   <= '0;
            fifo_count    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            err_last      <= 1'b0;
        end else begin
            if (a_hs) begin
                addr          <= s_aaddr;
                req_remaining <= s_abeats;
                pop_remaining <= s_abeats;
            end
            if (w_hs || ar_hs) begin
                addr          <= addr + ADDR_WIDTH'(BYTES);
                req_remaining <= req_remaining - ADDR_WIDTH'(1);
            end
            // Termination is count-based; a misplaced tlast only flags.
            if (w_hs && (s_axis_tlast != (req_remaining == ADDR_WIDTH'(1)))) begin
                err_last <= 1'b1;
            end
            case ({ar_hs, push})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH_LG'(1);
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + FIFO_DEPTH_LG'(1);
                pop_remaining <= pop_remaining - ADDR_WIDTH'(1);
            end
        end
    end

    // Read FIFO storage; contents are only observed through the counted head
    always_ff @(posedge aclk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_framebuffer_stream_responder.sv
// Self-checking bench for framebuffer_stream_responder: table of directed
// transfers, randomized transfers against a transaction-level model, and a
// hand-written mid-transfer reset sequence.
module tb_framebuffer_stream_responder;

    localparam int unsigned SW    = 32;
    localparam int unsigned AW    = 32;
    localparam int unsigned SB    = SW / 8;
    localparam int unsigned DEPTH = 4;

    logic          aclk = 1'b0;
    logic          resetn;
    logic          s_avalid;
    logic          s_aready;
    logic [AW-1:0] s_aaddr;
    logic [AW-1:0] s_abeats;
    logic          s_arnw;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic          s_axis_tlast;
    logic [SW-1:0] s_axis_tdata;
    logic [SB-1:0] s_axis_tstrb;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic [SW-1:0] m_axis_tdata;
    logic          mem_wvalid;
    logic          mem_wready;
    logic [AW-1:0] mem_waddr;
    logic [SW-1:0] mem_wdata;
    logic [SB-1:0] mem_wstrb;
    logic          mem_arvalid;
    logic          mem_arready;
    logic [AW-1:0] mem_araddr;
    logic          mem_rvalid;
    logic [SW-1:0] mem_rdata;
    logic          busy;
    logic          err_last;

    framebuffer_stream_responder #(
        .STREAM_WIDTH (SW),
        .ADDR_WIDTH   (AW),
        .FIFO_DEPTH_LG(2)
    ) dut (
        .aclk          (aclk),
        .resetn        (resetn),
        .s_avalid      (s_avalid),
        .s_aready      (s_aready),
        .s_aaddr       (s_aaddr),
        .s_abeats      (s_abeats),
        .s_arnw        (s_arnw),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tstrb  (s_axis_tstrb),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .mem_wvalid    (mem_wvalid),
        .mem_wready    (mem_wready),
        .mem_waddr     (mem_waddr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_arvalid   (mem_arvalid),
        .mem_arready   (mem_arready),
        .mem_araddr    (mem_araddr),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .busy          (busy),
        .err_last      (err_last)
    );

    always #5 aclk = ~aclk;

    typedef struct { logic [AW-1:0] addr; logic [SW-1:0] data; logic [SB-1:0] strb; } wr_t;
    typedef struct { logic [SW-1:0] data; logic [SB-1:0] strb; logic last; } beat_t;
    typedef struct { logic [AW-1:0] addr; int due; } pend_t;
    typedef struct { logic [SW-1:0] data; logic last; } rd_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [AW-1:0] beats;
        bit            rnw;
        int            bad_last;   // 1-based beat carrying tlast, 0 = correct
        int            stall;      // cycles of m_axis_tready low at start
        int            wr_pct;
        int            m_pct;
        bit            exp_err;    // err_last expected after this transfer
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    beat_t wq[$];
    wr_t   got_w[$];
    pend_t pend[$];
    rd_t   got_r[$];

    int issued;
    int popped;
    int wr_ready_pct = 100;
    int ar_ready_pct = 100;
    int m_ready_pct  = 100;
    int lat          = 3;
    int stall_left   = 0;
    bit model_err    = 1'b0;
    bit prev_hold    = 1'b0;
    logic [SW-1:0] prev_data;

    function automatic logic [SW-1:0] mem_val(input logic [AW-1:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, sample settled outputs, advance to next negedge.
    task automatic cycle();
        rd_t   r;
        wr_t   w;
        pend_t p;
        mem_wready  = ($urandom_range(99) < wr_ready_pct);
        mem_arready = ($urandom_range(99) < ar_ready_pct);
        if (stall_left > 0) begin
            m_axis_tready = 1'b0;
            stall_left--;
        end else begin
            m_axis_tready = ($urandom_range(99) < m_ready_pct);
        end
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            mem_rvalid = 1'b1;
            mem_rdata  = mem_val(pend[0].addr);
            void'(pend.pop_front());
        end
        if (wq.size() > 0) begin
            if (!s_axis_tvalid) s_axis_tvalid = ($urandom_range(3) != 0);
            s_axis_tdata = wq[0].data;
            s_axis_tstrb = wq[0].strb;
            s_axis_tlast = wq[0].last;
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tlast  = 1'b0;
        end
        #1;
        if (s_axis_tvalid && s_axis_tready) void'(wq.pop_front());
        if (mem_wvalid && mem_wready) begin
            w.addr = mem_waddr; w.data = mem_wdata; w.strb = mem_wstrb;
            got_w.push_back(w);
        end
        if (mem_arvalid && mem_arready) begin
            check("read_credit", 64'((issued - popped) < int'(DEPTH)), 64'd1);
            p.addr = mem_araddr; p.due = cyc + lat;
            pend.push_back(p);
            issued++;
        end
        if (prev_hold) begin
            check("m_axis_hold_valid", m_axis_tvalid, 1'b1);
            check("m_axis_hold_data", m_axis_tdata, prev_data);
        end
        prev_hold = m_axis_tvalid && !m_axis_tready;
        prev_data = m_axis_tdata;
        if (m_axis_tvalid && m_axis_tready) begin
            r.data = m_axis_tdata; r.last = m_axis_tlast;
            got_r.push_back(r);
            popped++;
        end
        @(posedge aclk);
        cyc++;
        @(negedge aclk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_aready"}, s_aready, 1'b1);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_err_last"}, err_last, 1'b0);
        check({tag, "_s_axis_tready"}, s_axis_tready, 1'b0);
        check({tag, "_m_axis_tvalid"}, m_axis_tvalid, 1'b0);
        check({tag, "_m_axis_tlast"}, m_axis_tlast, 1'b0);
        check({tag, "_m_axis_tdata"}, m_axis_tdata, '0);
        check({tag, "_mem_wvalid"}, mem_wvalid, 1'b0);
        check({tag, "_mem_waddr"}, mem_waddr, '0);
        check({tag, "_mem_wdata"}, mem_wdata, '0);
        check({tag, "_mem_wstrb"}, mem_wstrb, '0);
        check({tag, "_mem_arvalid"}, mem_arvalid, 1'b0);
        check({tag, "_mem_araddr"}, mem_araddr, '0);
    endtask

    // Run one complete transfer and compare against the transaction model.
    task automatic run_vec(input logic [AW-1:0] addr, input logic [AW-1:0] beats, input bit rnw,
                           input int bad_last, input int stall, input string name);
        wr_t   exp_w[$];
        wr_t   ew;
        beat_t b;
        int    n;
        int    k;
        n = int'(beats);
        got_w.delete();
        got_r.delete();
        issued = 0;
        popped = 0;
        if (!rnw) begin
            for (int i = 0; i < n; i++) begin
                b.data = $urandom;
                b.strb = SB'($urandom_range(15));
                b.last = (bad_last > 0) ? (i == bad_last - 1) : (i == n - 1);
                if (b.last != (i == n - 1)) model_err = 1'b1;
                wq.push_back(b);
                ew.addr = addr + AW'(SB * i);
                ew.data = b.data;
                ew.strb = b.strb;
                exp_w.push_back(ew);
            end
        end
        check({name, "_aready_before"}, s_aready, 1'b1);
        s_avalid = 1'b1;
        s_aaddr  = addr;
        s_abeats = beats;
        s_arnw   = rnw;
        cycle();
        s_avalid = 1'b0;
        s_aaddr  = '0;
        s_abeats = '0;
        s_arnw   = 1'b0;
        if (n == 0) begin
            for (int i = 0; i < 5; i++) begin
                check({name, "_zero_busy"}, busy, 1'b0);
                cycle();
            end
            check({name, "_zero_traffic"}, 64'(got_w.size() + got_r.size() + issued), 64'd0);
            check({name, "_zero_aready"}, s_aready, 1'b1);
        end else begin
            check({name, "_busy_after_accept"}, busy, 1'b1);
            if (rnw && ar_ready_pct == 100 && stall == 0)
                check({name, "_ar_first"}, mem_arvalid, 1'b1);
            if (stall > 0) begin
                stall_left = stall;
                for (int i = 0; i < stall; i++) cycle();
                check({name, "_stall_issued"}, 64'(issued), 64'(DEPTH));
                check({name, "_stall_popped"}, 64'(popped), 64'd0);
            end
            k = 0;
            while ((rnw ? got_r.size() : got_w.size()) < n && k < 3000) begin
                cycle();
                k++;
            end
            check({name, "_done_in_time"}, 64'(k < 3000), 64'd1);
            check({name, "_aready_after"}, s_aready, 1'b1);
            check({name, "_busy_after"}, busy, 1'b0);
            if (rnw) begin
                check({name, "_rd_count"}, 64'(got_r.size()), 64'(n));
                check({name, "_issued"}, 64'(issued), 64'(n));
                for (int i = 0; i < n && i < got_r.size(); i++) begin
                    check($sformatf("%s_rdata%0d", name, i), got_r[i].data, mem_val(addr + AW'(SB * i)));
                    check($sformatf("%s_rlast%0d", name, i), got_r[i].last, (i == n - 1));
                end
            end else begin
                check({name, "_wr_count"}, 64'(got_w.size()), 64'(n));
                check({name, "_stream_drained"}, 64'(wq.size()), 64'd0);
                for (int i = 0; i < n && i < got_w.size(); i++) begin
                    check($sformatf("%s_waddr%0d", name, i), got_w[i].addr, exp_w[i].addr);
                    check($sformatf("%s_wdata%0d", name, i), got_w[i].data, exp_w[i].data);
                    check($sformatf("%s_wstrb%0d", name, i), got_w[i].strb, exp_w[i].strb);
                end
            end
        end
        check({name, "_err_last_model"}, err_last, model_err);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        int   k;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        bit   rr;
        int   bl;

        tbl[0] = '{32'h0000_0100, 32'd4,  1'b0, 0, 0,  60, 100, 1'b0};
        tbl[1] = '{32'h0000_2000, 32'd8,  1'b1, 0, 0, 100, 100, 1'b0};
        tbl[2] = '{32'h0000_3000, 32'd16, 1'b1, 0, 20, 100, 100, 1'b0};
        tbl[3] = '{32'h0000_4000, 32'd0,  1'b1, 0, 0, 100, 100, 1'b0};
        tbl[4] = '{32'hFFFF_FFF8, 32'd4,  1'b1, 0, 0, 100,  70, 1'b0};
        tbl[5] = '{32'hFFFF_FFFC, 32'd3,  1'b0, 0, 0,  50, 100, 1'b0};
        tbl[6] = '{32'h0000_0500, 32'd3,  1'b0, 2, 0,  70, 100, 1'b1};

        resetn        = 1'b0;
        s_avalid      = 1'b0;
        s_aaddr       = '0;
        s_abeats      = '0;
        s_arnw        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tstrb  = '0;
        m_axis_tready = 1'b0;
        mem_wready    = 1'b0;
        mem_arready   = 1'b0;
        mem_rvalid    = 1'b0;
        mem_rdata     = '0;
        repeat (2) @(negedge aclk);
        check_reset_outputs("reset");
        resetn = 1'b1;
        cycle();

        for (int t = 0; t < 7; t++) begin
            wr_ready_pct = tbl[t].wr_pct;
            m_ready_pct  = tbl[t].m_pct;
            ar_ready_pct = 100;
            lat          = 3;
            run_vec(tbl[t].addr, tbl[t].beats, tbl[t].rnw, tbl[t].bad_last, tbl[t].stall,
                    $sformatf("v%0d", t));
            check($sformatf("v%0d_err_last", t), err_last, tbl[t].exp_err);
        end

        for (int t = 0; t < 25; t++) begin
            ra = AW'($urandom) & ~AW'(SB - 1);
            rb = AW'($urandom_range(10));
            rr = 1'($urandom_range(1));
            bl = (!rr && rb != '0 && $urandom_range(7) == 0) ? $urandom_range(int'(rb), 1) : 0;
            wr_ready_pct = $urandom_range(100, 30);
            ar_ready_pct = $urandom_range(100, 30);
            m_ready_pct  = $urandom_range(100, 30);
            lat          = $urandom_range(4, 1);
            run_vec(ra, rb, rr, bl, 0, $sformatf("r%0d", t));
        end

        // Reset while beat 5 of a 10-beat read is pending
        wr_ready_pct = 100;
        ar_ready_pct = 100;
        m_ready_pct  = 100;
        lat          = 3;
        got_r.delete();
        issued = 0;
        popped = 0;
        s_avalid = 1'b1;
        s_aaddr  = 32'h0000_6000;
        s_abeats = 32'd10;
        s_arnw   = 1'b1;
        cycle();
        s_avalid = 1'b0;
        s_aaddr  = '0;
        s_abeats = '0;
        s_arnw   = 1'b0;
        k = 0;
        while (popped < 4 && k < 200) begin
            cycle();
            k++;
        end
        check("mid_reset_reach_beat5", 64'(k < 200), 64'd1);
        check("mid_reset_busy_before", busy, 1'b1);
        resetn = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        prev_hold = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("post_reset_idle_tvalid", m_axis_tvalid, 1'b0);
        end
        model_err = 1'b0;
        run_vec(32'h0000_7000, 32'd2, 1'b0, 0, 0, "post_reset_write");
        run_vec(32'h0000_8000, 32'd4, 1'b1, 0, 0, "post_reset_read");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
